// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared state, source and request types for the write-back port arbiter
package rv_wb_pkg;
  typedef enum logic [1:0] {WB_IDLE, WB_PEND, WB_FORCE} wb_state_t;
  typedef enum logic {WB_SRC_PIPE = 1'b0, WB_SRC_MDU = 1'b1} wb_src_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;
endpackage

// File: rtl/rv_wb_fifo.sv
// rv_wb_fifo: synchronous FIFO of MDU write-back requests with occupancy count
module rv_wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  wb_req_t       i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output wb_req_t       o_head
);
  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  // pointers wrap naturally; push and pop together leave the count unchanged
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage needs no reset: the count decides what is valid
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: shares the regfile write port between pipeline write-back and MDU results (option RV_WB_MDU_BYPASS_EN)
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_reg_write,
  input  logic [4:0]  i_pipe_rd,
  input  logic [31:0] i_pipe_data,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_rd,
  input  logic [31:0] i_mdu_data,
  output logic        o_mdu_ready,
  output logic        o_stall,
  output logic        o_reg_write,
  output logic [4:0]  o_rd,
  output logic [31:0] o_data,
  output logic        o_src,
  output logic        o_mdu_pending
);
  localparam int AW = $clog2(DEPTH);
  wb_state_t   r_state;
  wb_state_t   w_state_nxt;
  logic [7:0]  r_starve;
  logic [7:0]  w_starve_nxt;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  wb_req_t     w_head;
  wb_req_t     w_mdu_req;
  logic        w_pipe_wants;
  logic        w_hs;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic        w_force;
  logic        w_nonempty_nxt;
  wb_src_t     w_src;
  assign w_pipe_wants = i_pipe_reg_write & (i_pipe_rd != 5'd0);
  assign o_mdu_ready  = ~i_reset & ~w_full;
  assign w_hs         = i_mdu_valid & o_mdu_ready;
  assign w_force      = r_state == WB_FORCE;
  assign w_mdu_req    = '{rd: i_mdu_rd, data: i_mdu_data};
`ifdef RV_WB_MDU_BYPASS_EN
  assign w_bypass = w_hs & (i_mdu_rd != 5'd0) & w_empty & ~w_pipe_wants;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_push = w_hs & (i_mdu_rd != 5'd0) & ~w_bypass;
  assign w_pop  = ~i_reset & ~w_empty & (w_force | ~w_pipe_wants);
  rv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_mdu_req),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );
  // state and starvation counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= WB_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end
  // arbitration: forced MDU slot, then pipeline, then FIFO head (or same-cycle bypass)
  always_comb begin
    w_src          = (w_pop | w_bypass) ? WB_SRC_MDU : WB_SRC_PIPE;
    o_src          = w_src;
    o_stall        = ~i_reset & w_force;
    o_reg_write    = w_pop | w_bypass | (~i_reset & ~w_force & w_pipe_wants);
    o_rd           = w_pop ? w_head.rd : w_bypass ? i_mdu_rd : i_pipe_rd;
    o_data         = w_pop ? w_head.data : w_bypass ? i_mdu_data : i_pipe_data;
    o_mdu_pending  = ~i_reset & ~w_empty;
    w_starve_nxt   = w_pop ? 8'd0 : (r_state == WB_PEND) ? r_starve + 8'd1 : r_starve;
    w_nonempty_nxt = w_push | (w_count > (AW+1)'(1)) | (~w_empty & ~w_pop);
    w_state_nxt    = (r_state == WB_PEND && !w_pop && w_starve_nxt == 8'(STARVE_LIMIT)) ? WB_FORCE :
                     w_nonempty_nxt ? WB_PEND : WB_IDLE;
  end
endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb_rv_wb_arbiter: scoreboard bench with a queue-level reference model of the write-back arbiter
module tb_rv_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        src;
    logic        stall;
    logic        ready;
    logic        pending;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pw = 1'b0;
  logic [4:0]  prd = '0;
  logic [31:0] pd = '0;
  logic        mv = 1'b0;
  logic [4:0]  mrd = '0;
  logic [31:0] md = '0;
  logic        o_mdu_ready, o_stall, o_reg_write, o_src, o_mdu_pending;
  logic [4:0]  o_rd;
  logic [31:0] o_data;
  exp_t        exp_q[$];
  logic [36:0] mdl_q[$];
  int          denied = 0;
  bit          force_m = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  rv_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_pipe_reg_write(pw), .i_pipe_rd(prd), .i_pipe_data(pd),
    .i_mdu_valid(mv), .i_mdu_rd(mrd), .i_mdu_data(md),
    .o_mdu_ready(o_mdu_ready), .o_stall(o_stall), .o_reg_write(o_reg_write),
    .o_rd(o_rd), .o_data(o_data), .o_src(o_src), .o_mdu_pending(o_mdu_pending)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endfunction
  // one cycle of stimulus; the model predicts the port's behaviour and the next queue contents
  task automatic step(input bit r, input bit p_w, input logic [4:0] p_rd, input logic [31:0] p_d,
                      input bit m_v, input logic [4:0] m_rd, input logic [31:0] m_d, output bit acc);
    exp_t e;
    bit popped, byp, was_ne, wants;
    rst = r; pw = p_w; prd = p_rd; pd = p_d; mv = m_v; mrd = m_rd; md = m_d;
    e = '0; acc = 0; popped = 0; byp = 0;
    if (r) begin
      mdl_q.delete(); denied = 0; force_m = 0;
    end else begin
      wants = p_w && p_rd != 0;
      e.ready = mdl_q.size() < DEPTH;
      e.pending = mdl_q.size() != 0;
      acc = m_v && e.ready;
      if (force_m) begin
        e.stall = 1; e.we = 1; e.src = 1; {e.rd, e.data} = mdl_q[0]; popped = 1;
      end else if (wants) begin
        e.we = 1; e.rd = p_rd; e.data = p_d;
      end else if (mdl_q.size() != 0) begin
        e.we = 1; e.src = 1; {e.rd, e.data} = mdl_q[0]; popped = 1;
      end
`ifdef RV_WB_MDU_BYPASS_EN
      else if (acc && m_rd != 0) begin
        e.we = 1; e.src = 1; e.rd = m_rd; e.data = m_d; byp = 1;
      end
`endif
      was_ne = mdl_q.size() != 0;
      if (popped) begin
        void'(mdl_q.pop_front()); denied = 0;
      end else if (was_ne) denied++;
      if (acc && m_rd != 0 && !byp) mdl_q.push_back({m_rd, m_d});
      force_m = !popped && was_ne && denied == LIMIT;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask
  // monitor: compare the write port against the oldest prediction while outputs are stable
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ready", o_mdu_ready, e.ready);
      chk("stall", o_stall, e.stall);
      chk("reg_write", o_reg_write, e.we);
      chk("src", o_src, e.src);
      chk("pending", o_mdu_pending, e.pending);
      if (e.we) begin
        chk("rd", o_rd, e.rd);
        chk("data", o_data, e.data);
      end
      if (o_reg_write) chk("rd_nonzero", o_rd != 0, 1);
    end
  end
  initial begin
    bit a, hold;
    int idx;
    logic [4:0] h_rd;
    logic [31:0] h_d;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 1, 5'd4, 32'h1, a);
    step(1, 0, 0, 0, 1, 5'd4, 32'h1, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    step(0, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22, a);
    for (int i = 0; i < 8; i++) step(0, 1, 5'd3, 32'h11, 0, 0, 0, a);
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, i < 6, 5'd3, 32'h33 + i, idx < 3, 5'd10 + 5'(idx), 32'hA0 + idx, a);
      if (a) idx++;
    end
    step(0, 1, 5'd3, 32'h44, 1, 5'd9, 32'h99, a);
    step(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'h66, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    step(0, 1, 5'd3, 32'h77, 1, 5'd9, 32'h909, a);
    step(0, 0, 0, 0, 1, 5'd13, 32'h1313, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    hold = 0; h_rd = 0; h_d = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold && $urandom_range(0, 2) != 0) begin
        hold = 1; h_rd = 5'($urandom_range(0, 31)); h_d = $urandom;
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
           $urandom, hold, h_rd, h_d, a);
      if (a || rst) hold = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, a);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
